// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   Small ALU with a valid/ready request side and a valid/ready result side.
//   ADD, SUB, SRF and SLF finish one cycle after acceptance. MUL is an unsigned
//   shift-add multiplier that takes WIDTH cycles and produces a 2*WIDTH-bit
//   product. A single flag register acts as carry/borrow, shift-in/shift-out
//   bit, or "high word non-zero" indicator, and persists between operations.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request valid
//   in_ready   : block can accept a request (high only in IDLE)
//   op         : 000 ADD, 001 SUB, 010 SRF, 011 SLF, 100 MUL, others reserved
//   use_flag   : ADD/SUB take the flag register as carry-in
//   srcA, srcB : operands
//   out_valid  : result valid (high only in DONE)
//   out_ready  : consumer takes the result
//   result     : result low word
//   result_hi  : MUL high word, zero for every other op
//   flagout    : current flag register
//   zero       : result == 0 while out_valid is high
//   err        : result came from a reserved op
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int   WIDTH    = 8,
  parameter logic FLAG_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_flag,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flagout,
  output logic             zero,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SRF = 3'b010;
  localparam logic [2:0] OP_SLF = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             flag;
  logic             err_r;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             last_step;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_err;
  logic             alu_cin;

  assign accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (last_step) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Shift-add step: the low half of the accumulator starts as the multiplier
  // and is shifted out LSB first while product bits shift in from the top.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    step_hi   = step_sum[WIDTH:1];
    step_lo   = {step_sum[0], acc_lo[WIDTH-1:1]};
    last_step = (cnt == CNT_W'(1));
  end

  // Single-cycle operations
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = flag;
    alu_err = 1'b0;
    alu_cin = 1'b0;
    case (op)
      OP_ADD: begin
        alu_cin = use_flag & flag;
        alu_sum = {1'b0, srcA} + {1'b0, srcB} + (WIDTH+1)'(alu_cin);
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
      end
      OP_SUB: begin
        // Carry out of A + ~B + cin is 1 when no borrow occurred.
        alu_cin = use_flag ? flag : 1'b1;
        alu_sum = {1'b0, srcA} + {1'b0, ~srcB} + (WIDTH+1)'(alu_cin);
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
      end
      OP_SRF: begin
        alu_res = {flag, srcA[WIDTH-1:1]};
        alu_c   = srcA[0];
      end
      OP_SLF: begin
        alu_res = {srcA[WIDTH-2:0], flag};
        alu_c   = srcA[WIDTH-1];
      end
      OP_MUL: begin
        alu_res = '0;
      end
      default: begin
        alu_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers; result and flag change only on the edge entering DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      res_lo <= '0;
      res_hi <= '0;
      flag   <= FLAG_RST;
      err_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand  <= srcA;
              acc_lo <= srcB;
              acc_hi <= '0;
              cnt    <= CNT_W'(WIDTH);
            end else begin
              res_lo <= alu_res;
              res_hi <= '0;
              err_r  <= alu_err;
              flag   <= alu_c;
            end
          end
        end
        S_MUL: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CNT_W'(1);
          if (last_step) begin
            res_lo <= step_lo;
            res_hi <= step_hi;
            err_r  <= 1'b0;
            flag   <= |step_hi;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = res_lo;
  assign result_hi = res_hi;
  assign flagout   = flag;
  assign err       = err_r;
  assign zero      = out_valid & (res_lo == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//   Directed testbench for multicycle_alu (WIDTH = 8). The stimulus process
//   pushes hand-computed expected results into a scoreboard queue; a monitor
//   pops and compares on every result handoff (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_multicycle_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       use_flag;
  logic [7:0] srcA;
  logic [7:0] srcB;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       flagout;
  logic       zero;
  logic       err;

  multicycle_alu #(.WIDTH(8), .FLAG_RST(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .use_flag  (use_flag),
    .srcA      (srcA),
    .srcB      (srcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flagout   (flagout),
    .zero      (zero),
    .err       (err)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       flg;
    logic       zr;
    logic       er;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   handoffs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every handoff against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result 0x%0h with empty scoreboard at %0t", result, $time);
        end else begin
          e = sbq.pop_front();
          chk("result",    32'(result),    32'(e.res));
          chk("result_hi", 32'(result_hi), 32'(e.hi));
          chk("flagout",   32'(flagout),   32'(e.flg));
          chk("zero",      32'(zero),      32'(e.zr));
          chk("err",       32'(err),       32'(e.er));
          handoffs++;
        end
      end
    end
  end

  // Issue one request; caller is just after a rising edge. Returns just after
  // the rising edge that completes the handoff. With stall set, out_ready is
  // held low for three extra cycles while in_valid pulses are applied.
  task automatic issue(input logic [2:0] o, input logic uf, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e_res, input logic [7:0] e_hi,
                       input logic e_flg, input logic e_zr, input logic e_er,
                       input int e_lat, input bit stall);
    exp_t e;
    int   lat;
    int   busy_ready;
    bit   got;
    e.res = e_res; e.hi = e_hi; e.flg = e_flg; e.zr = e_zr; e.er = e_er;
    sbq.push_back(e);
    out_ready = stall ? 1'b0 : 1'b1;
    op = o; use_flag = uf; srcA = a; srcB = b; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0; lat = 0; busy_ready = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        lat = i;
      end else if (in_ready) begin
        busy_ready++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid not seen within 40 cycles for op %0d", o);
      return;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("in_ready_while_busy", 32'(busy_ready), 32'd0);
    if (stall) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = 3'b000; use_flag = 1'b1; srcA = 8'hFF; srcB = 8'hFF;
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_result",    32'(result),    32'(e_res));
        chk("stall_flagout",   32'(flagout),   32'(e_flg));
        chk("stall_in_ready",  32'(in_ready),  32'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b000; use_flag = 1'b0; srcA = 8'h00; srcB = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_result_hi", 32'(result_hi), 32'd0);
    chk("rst_flagout",   32'(flagout),   32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    //      op      uf    A      B      res    hi     flg   zr    er   lat stall
    issue(3'b000, 1'b0, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // ADD carry out
    issue(3'b000, 1'b1, 8'h01, 8'h01, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // ADD with carry-in
    issue(3'b011, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1, 0); // SLF
    issue(3'b100, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 9, 0); // MUL max
    issue(3'b001, 1'b0, 8'h50, 8'h20, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1); // SUB, stalled
    issue(3'b110, 1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1, 0); // reserved
    issue(3'b001, 1'b0, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // SUB borrow
    issue(3'b001, 1'b1, 8'h10, 8'h05, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // SUB borrow-in
    issue(3'b010, 1'b0, 8'h03, 8'h00, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // SRF
    issue(3'b100, 1'b0, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 9, 0); // MUL small
    issue(3'b100, 1'b0, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9, 0); // MUL by zero
    issue(3'b000, 1'b0, 8'hFF, 8'h02, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // ADD, flag=1

    // MUL interrupted by reset during its fourth cycle; nothing is queued.
    op = 3'b100; use_flag = 1'b0; srcA = 8'h12; srcB = 8'h34; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_result",    32'(result),    32'd0);
    chk("midmul_rst_result_hi", 32'(result_hi), 32'd0);
    chk("midmul_rst_flagout",   32'(flagout),   32'd0);
    chk("midmul_rst_err",       32'(err),       32'd0);
    chk("midmul_rst_zero",      32'(zero),      32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready",  32'(in_ready),  32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (12) @(posedge clk);
    #1 chk("discarded_mul_no_output", 32'(out_valid), 32'd0);

    issue(3'b000, 1'b1, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // flag came from reset

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    chk("handoff_count",    32'(handoffs),   32'd13);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 4..32.
REQ-002 Parameter FLAG_RST, default 1'b0, sets the value loaded into the internal flag register at reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  3  operation: 000 ADD, 001 SUB, 010 SRF, 011 SLF, 100 MUL; 101-111 reserved.
REQ-008 use_flag  input  1  ADD/SUB only: include the flag register as carry-in.
REQ-009 srcA  input  WIDTH  first operand.
REQ-010 srcB  input  WIDTH  second operand.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 result  output  WIDTH  result low word.
REQ-014 result_hi  output  WIDTH  MUL high word; zero for all other ops.
REQ-015 flagout  output  1  current flag register value.
REQ-016 zero  output  1  result == 0 while out_valid is high.
REQ-017 err  output  1  result came from a reserved op.

Function
REQ-018 A request is accepted only when in_valid and in_ready are both high; op, use_flag, srcA and srcB are captured in that cycle.
REQ-019 FSM states: IDLE, MUL, DONE; in_ready = (state == IDLE).
REQ-020 IDLE, accepted op other than MUL: compute, register the result, go to DONE; out_valid rises on the next cycle (latency 1).
REQ-021 IDLE, accepted MUL: clear the accumulator, load the counter with WIDTH, go to MUL.
REQ-022 MUL: one shift-add step per cycle, unsigned, LSB of the multiplier first; after WIDTH steps go to DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-023 DONE: out_valid = 1; result, result_hi, zero and err hold stable until out_ready = 1, then go to IDLE on the next edge.
REQ-024 out_valid and in_ready are never high in the same cycle; no request is accepted back-to-back with a result handoff.
REQ-025 ADD: {c, result} = srcA + srcB + (use_flag & flag); flag <= c.
REQ-026 SUB: {c, result} = srcA + ~srcB + 1 when use_flag = 0, or srcA + ~srcB + flag when use_flag = 1; flag <= c, where c = 1 means no borrow.
REQ-027 SRF: result = {flag, srcA[WIDTH-1:1]}; flag <= srcA[0].
REQ-028 SLF: result = {srcA[WIDTH-2:0], flag}; flag <= srcA[WIDTH-1].
REQ-029 MUL: {result_hi, result} = srcA * srcB, full 2*WIDTH-bit product; flag <= (result_hi != 0).
REQ-030 Reserved op: result = 0, result_hi = 0, err = 1, flag unchanged, latency 1.
REQ-031 The flag register updates once per operation, on the edge that enters DONE, and otherwise persists across operations.
REQ-032 in_valid while in MUL or DONE is ignored and causes no side effect.

Reset
REQ-033 rst_n = 0 forces, asynchronously and in any state including mid-MUL: state IDLE, out_valid 0, result 0, result_hi 0, zero 0, err 0, flag FLAG_RST, counter 0.
REQ-034 After rst_n is released, in_ready = 1 at the first rising edge; any partial MUL is discarded.

Verification (WIDTH = 8)
REQ-035 ADD, srcA = 0xF0, srcB = 0x20, use_flag = 0 -> result 0x10, flagout 1, out_valid 1 cycle after acceptance.
REQ-036 Next, ADD, srcA = 0x01, srcB = 0x01, use_flag = 1 -> result 0x03, flagout 0; then SLF, srcA = 0x80 with flag = 0 -> result 0x00, zero 1, flagout 1.
REQ-037 MUL, srcA = 0xFF, srcB = 0xFF -> result 0x01, result_hi 0xFE, flagout 1, out_valid exactly 9 cycles after acceptance, in_ready 0 throughout.
REQ-038 Result with out_ready held 0 for 3 cycles -> out_valid, result and flagout stable; in_valid pulses during those cycles are ignored.
REQ-039 rst_n pulsed low during MUL cycle 4 -> outputs zero immediately, flagout = FLAG_RST, in_ready 1 at the first edge after release.
REQ-040 op = 110, srcA = 0x55 -> err 1, result 0x00, flagout unchanged, latency 1.
